bank_cmd_arbiter: RTL and testbench



---
 rtl/bank_cmd_arbiter_pkg.sv | 36 +++
 rtl/bank_cmd_arbiter_if.sv | 34 +++
 rtl/bank_cmd_arbiter_rr_pick.sv | 43 ++++
 rtl/bank_cmd_arbiter.sv | 122 ++++++++++++
 tb/tb_bank_cmd_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types for the bank command arbiter: bank count, request direction
// encoding, request field positions and the packed request layout produced
// by the per-bank schedulers (mirrors the front_end types_def contents).
package bank_cmd_arbiter_pkg;

    localparam int unsigned banks_no    = 16;
    localparam int unsigned BANK_W      = $clog2(banks_no);
    localparam int unsigned REQ_W       = 50;
    localparam int unsigned MAX_RUN_DEF = 8;

    // Request direction encoding
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Field LSB positions inside a request vector
    localparam int unsigned COL_LSB   = 0;
    localparam int unsigned ROW_LSB   = 10;
    localparam int unsigned DATA_LSB  = 26;
    localparam int unsigned TYPE_LSB  = 42;
    localparam int unsigned INDEX_LSB = 43;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_e;

    // {index, type, data, row, col} = 7 + 1 + 16 + 16 + 10 bits
    typedef struct packed {
        logic [6:0]  index;
        logic        rtype;
        logic [15:0] data;
        logic [15:0] row;
        logic [9:0]  col;
    } opt_request;

endpackage : bank_cmd_arbiter_pkg

// File: rtl/bank_cmd_arbiter_if.sv
// Bundle of the bank-side handshake and the output slot of the arbiter.
//   req_i/valid_i/ready_o : per-bank request handshake (transfer = valid & ready)
//   out_req/out_bank/out_valid/out_ready : single registered slot to the back end
//   mode_o : current arbitration direction
// master = bank schedulers + back end, slave = arbiter.
interface bank_cmd_arbiter_if
    import bank_cmd_arbiter_pkg::*;
#(
    parameter int unsigned BANKS    = banks_no,
    parameter int unsigned REQ_SIZE = REQ_W
) ();

    localparam int unsigned IDX_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [BANKS-1:0][REQ_SIZE-1:0] req_i;
    logic [BANKS-1:0]               valid_i;
    logic [BANKS-1:0]               ready_o;
    logic [REQ_SIZE-1:0]            out_req;
    logic [IDX_W-1:0]               out_bank;
    logic                           out_valid;
    logic                           out_ready;
    logic                           mode_o;

    modport master (
        output req_i, valid_i, out_ready,
        input  ready_o, out_req, out_bank, out_valid, mode_o
    );

    modport slave (
        input  req_i, valid_i, out_ready,
        output ready_o, out_req, out_bank, out_valid, mode_o
    );

endinterface : bank_cmd_arbiter_if

// File: rtl/bank_cmd_arbiter_rr_pick.sv
// Round-robin first-set-bit finder: searches mask_i upward starting at
// ptr_i, wrapping past BANKS-1 back to 0.
//   mask_i  : candidate mask
//   ptr_i   : search start position
//   grant_o : one-hot of the selected bit (zero when nothing is set)
//   idx_o   : encoded index of the selected bit
//   found_o : some bit of mask_i was set
module bank_cmd_arbiter_rr_pick #(
    parameter int unsigned BANKS = 16,
    localparam int unsigned IDX_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic [BANKS-1:0] mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [BANKS-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    function automatic logic [IDX_W-1:0] wrap_add(logic [IDX_W-1:0] p, int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        return IDX_W'(s % BANKS);
    endfunction

    logic [IDX_W-1:0] pos_c;

    // Scan from the pointer; first hit wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos_c   = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            pos_c = wrap_add(ptr_i, i);
            if (!found_o && mask_i[pos_c]) begin
                found_o = 1'b1;
                idx_o   = pos_c;
            end
        end
    end

    assign grant_o = found_o ? (BANKS'(1) << idx_o) : '0;

endmodule : bank_cmd_arbiter_rr_pick

// File: rtl/bank_cmd_arbiter.sv
// Bank command arbiter: picks at most one pending bank request per cycle
// and moves it into a single registered output slot. Banks are served
// round-robin within the current direction; the direction flips when only
// the other direction is pending or when the current direction has used
// MAX_RUN consecutive grants while the other direction waits. A flip costs
// one bubble cycle without a grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_if     : slave side of bank_cmd_arbiter_if (bank handshake,
//                output slot, direction indicator)
module bank_cmd_arbiter
    import bank_cmd_arbiter_pkg::*;
#(
    parameter int unsigned BANKS    = banks_no,
    parameter int unsigned REQ_SIZE = REQ_W,
    parameter int unsigned TYPE_POS = TYPE_LSB,
    parameter int unsigned MAX_RUN  = MAX_RUN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    bank_cmd_arbiter_if.slave bus_if
);

    localparam int unsigned IDX_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);

    mode_e               mode_q,      mode_d;
    logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [RUN_W-1:0]    run_cnt_q,   run_cnt_d;
    logic [REQ_SIZE-1:0] out_req_q,   out_req_d;
    logic [IDX_W-1:0]    out_bank_q,  out_bank_d;
    logic                out_valid_q, out_valid_d;

    logic [BANKS-1:0]    cand_c;
    logic [BANKS-1:0]    other_c;
    logic [BANKS-1:0]    pick_oh_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic                pick_found_c;
    logic                slot_free_c;
    logic                switch_c;
    logic                grant_c;

    // Split valid requests by direction relative to the current mode
    always_comb begin
        cand_c  = '0;
        other_c = '0;
        for (int unsigned b = 0; b < BANKS; b++) begin
            if (bus_if.valid_i[b]) begin
                if (bus_if.req_i[b][TYPE_POS] == logic'(mode_q)) begin
                    cand_c[b] = 1'b1;
                end else begin
                    other_c[b] = 1'b1;
                end
            end
        end
    end

    bank_cmd_arbiter_rr_pick #(
        .BANKS (BANKS)
    ) u_rr_pick (
        .mask_i  (cand_c),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_oh_c),
        .idx_o   (pick_idx_c),
        .found_o (pick_found_c)
    );

    assign slot_free_c = !out_valid_q || bus_if.out_ready;

    // A pending flip suppresses the grant even when the slot is free
    assign switch_c = (|other_c) && (!pick_found_c || (run_cnt_q == RUN_W'(MAX_RUN)));
    assign grant_c  = slot_free_c && pick_found_c && !switch_c;

    assign bus_if.ready_o = grant_c ? pick_oh_c : '0;

    // Next-state: consumption always empties the slot; a grant refills it
    always_comb begin
        mode_d      = mode_q;
        rr_ptr_d    = rr_ptr_q;
        run_cnt_d   = run_cnt_q;
        out_req_d   = out_req_q;
        out_bank_d  = out_bank_q;
        out_valid_d = out_valid_q && !bus_if.out_ready;

        if (switch_c) begin
            mode_d    = (mode_q == MODE_READ) ? MODE_WRITE : MODE_READ;
            run_cnt_d = '0;
        end else if (grant_c) begin
            out_req_d   = bus_if.req_i[pick_idx_c];
            out_bank_d  = pick_idx_c;
            out_valid_d = 1'b1;
            rr_ptr_d    = (pick_idx_c == IDX_W'(BANKS - 1)) ? '0 : pick_idx_c + IDX_W'(1);
            if (run_cnt_q != RUN_W'(MAX_RUN)) begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
        end
    end

    // State and output slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_READ;
            rr_ptr_q    <= '0;
            run_cnt_q   <= '0;
            out_req_q   <= '0;
            out_bank_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            rr_ptr_q    <= rr_ptr_d;
            run_cnt_q   <= run_cnt_d;
            out_req_q   <= out_req_d;
            out_bank_q  <= out_bank_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus_if.out_req   = out_req_q;
    assign bus_if.out_bank  = out_bank_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.mode_o    = logic'(mode_q);

endmodule : bank_cmd_arbiter

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter. Stimulus pushes expected output-slot
// transfers into a scoreboard queue and expected per-cycle signal values
// into a probe queue; one monitor on the falling edge pops and compares.
module tb_bank_cmd_arbiter;
    import bank_cmd_arbiter_pkg::*;

    localparam int unsigned BANKS = banks_no;

    typedef struct {
        logic [BANK_W-1:0] bank;
        logic [REQ_W-1:0]  req;
    } slot_t;

    typedef enum int {P_READY, P_MODE, P_VALID, P_BANK, P_REQ} probe_e;

    typedef struct {
        int unsigned cyc;
        probe_e      kind;
        logic [63:0] val;
        string       name;
    } probe_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        end_req = 1'b0;
    logic        end_ack = 1'b0;

    slot_t  exp_q[$];
    probe_t probe_q[$];

    bank_cmd_arbiter_if #(.BANKS(BANKS), .REQ_SIZE(REQ_W)) bus_if ();

    bank_cmd_arbiter #(
        .BANKS    (BANKS),
        .REQ_SIZE (REQ_W),
        .TYPE_POS (TYPE_LSB),
        .MAX_RUN  (MAX_RUN_DEF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [REQ_W-1:0] mk_req(int unsigned bank, logic typ);
        opt_request r;
        r.index = 7'(bank);
        r.rtype = typ;
        r.data  = {8'hDA, 4'(bank), 3'b000, typ};
        r.row   = 16'(16'h0100 + bank);
        r.col   = 10'(bank * 3);
        return r;
    endfunction

    function automatic logic [63:0] sample(probe_e k);
        case (k)
            P_READY: return 64'(bus_if.ready_o);
            P_MODE:  return 64'(bus_if.mode_o);
            P_VALID: return 64'(bus_if.out_valid);
            P_BANK:  return 64'(bus_if.out_bank);
            default: return 64'(bus_if.out_req);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(probe_e k, logic [63:0] v, string nm);
        probe_t p;
        p.cyc  = cyc;
        p.kind = k;
        p.val  = v;
        p.name = nm;
        probe_q.push_back(p);
    endtask

    task automatic expect_slot(int unsigned bank, logic [REQ_W-1:0] r);
        slot_t s;
        s.bank = BANK_W'(bank);
        s.req  = r;
        exp_q.push_back(s);
    endtask

    // Monitor: per-cycle probes, slot transfers, and the final drain check
    probe_t      mp;
    slot_t       ms;
    logic [63:0] mact;
    always @(negedge clk) begin
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            mp   = probe_q.pop_front();
            mact = sample(mp.kind);
            n_checks++;
            if (mp.cyc != cyc || mact !== mp.val) begin
                n_errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, due %0d)",
                         mp.name, mact, mp.val, cyc, mp.cyc);
            end
        end
        if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL slot_unexpected: got bank %0d req 0x%0h expected no transfer",
                         bus_if.out_bank, bus_if.out_req);
            end else begin
                ms = exp_q.pop_front();
                if (bus_if.out_bank !== ms.bank || bus_if.out_req !== ms.req) begin
                    n_errors++;
                    $display("FAIL slot_xfer: got bank %0d req 0x%0h expected bank %0d req 0x%0h",
                             bus_if.out_bank, bus_if.out_req, ms.bank, ms.req);
                end
            end
        end
        if (end_req && !end_ack) begin
            n_checks++;
            if (exp_q.size() != 0 || probe_q.size() != 0) begin
                n_errors++;
                $display("FAIL drain: got %0d slots %0d probes pending expected 0 and 0",
                         exp_q.size(), probe_q.size());
            end
            end_ack = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100us");
        $fatal(1, "watchdog");
    end

    int t2_seq[6] = '{3, 7, 12, 3, 7, 12};

    initial begin
        rst_n            = 1'b0;
        bus_if.req_i     = '0;
        bus_if.valid_i   = '0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        probe(P_VALID, 64'd0, "rst_valid");
        probe(P_BANK,  64'd0, "rst_bank");
        probe(P_REQ,   64'd0, "rst_req");
        probe(P_READY, 64'd0, "rst_ready");
        probe(P_MODE,  64'd0, "rst_mode");
        #1 rst_n = 1'b1;
        tick();

        // Single read on bank 0: same-cycle ready, slot next cycle
        bus_if.req_i[0]  = mk_req(0, READ);
        bus_if.valid_i   = 16'h0001;
        bus_if.out_ready = 1'b1;
        probe(P_READY, 64'h0001, "t1_ready");
        probe(P_MODE,  64'd0,    "t1_mode");
        probe(P_VALID, 64'd0,    "t1_valid_pre");
        expect_slot(0, mk_req(0, READ));
        tick();
        bus_if.valid_i = '0;
        probe(P_VALID, 64'd1, "t1_valid");
        probe(P_BANK,  64'd0, "t1_bank");
        probe(P_READY, 64'd0, "t1_ready_idle");
        tick();
        probe(P_VALID, 64'd0, "t1_drained");

        // Reads on 3, 7, 12 held: round-robin from pointer 1 with wrap
        bus_if.req_i[3]  = mk_req(3, READ);
        bus_if.req_i[7]  = mk_req(7, READ);
        bus_if.req_i[12] = mk_req(12, READ);
        bus_if.valid_i   = 16'h1088;
        for (int i = 0; i < 6; i++) begin
            probe(P_READY, 64'(1) << t2_seq[i], "t2_ready");
            expect_slot(32'(t2_seq[i]), mk_req(32'(t2_seq[i]), READ));
            tick();
        end
        bus_if.valid_i = '0;
        tick();

        // Write only on bank 5 in READ mode: one bubble, then grant
        bus_if.req_i[5] = mk_req(5, WRITE);
        bus_if.valid_i  = 16'h0020;
        probe(P_READY, 64'd0, "t3_bubble");
        probe(P_MODE,  64'd0, "t3_mode_read");
        tick();
        probe(P_MODE,  64'd1,    "t3_mode_write");
        probe(P_READY, 64'h0020, "t3_ready");
        expect_slot(5, mk_req(5, WRITE));
        tick();
        bus_if.valid_i = '0;
        probe(P_BANK, 64'd5, "t3_bank");
        tick();

        // Back to READ, then reads 1..15 plus write on 0: 8 reads, bubble, write
        for (int b = 1; b < 16; b++) bus_if.req_i[b] = mk_req(32'(b), READ);
        bus_if.valid_i = 16'hFFFE;
        probe(P_READY, 64'd0, "t4_bubble_to_read");
        tick();
        bus_if.req_i[0] = mk_req(0, WRITE);
        bus_if.valid_i  = 16'hFFFF;
        probe(P_MODE, 64'd0, "t4_mode_read");
        for (int i = 0; i < 8; i++) expect_slot(32'(6 + i), mk_req(32'(6 + i), READ));
        expect_slot(0, mk_req(0, WRITE));
        for (int i = 0; i < 10; i++) begin
            if (i < 8)       probe(P_READY, 64'(1) << (6 + i), "t4_read_grant");
            else if (i == 8) probe(P_READY, 64'd0, "t4_run_bubble");
            else             probe(P_READY, 64'h0001, "t4_write_grant");
            tick();
        end
        bus_if.valid_i = '0;
        probe(P_MODE, 64'd1, "t4_mode_write");
        probe(P_BANK, 64'd0, "t4_bank");
        tick();

        // Back-pressure: slot holds bank 4 for 5 cycles, then drain + refill
        bus_if.req_i[4] = mk_req(4, WRITE);
        bus_if.req_i[9] = mk_req(9, WRITE);
        bus_if.valid_i  = 16'h0210;
        probe(P_READY, 64'h0010, "t5_ready_first");
        expect_slot(4, mk_req(4, WRITE));
        expect_slot(9, mk_req(9, WRITE));
        tick();
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            probe(P_READY, 64'd0, "t5_stall_ready");
            probe(P_VALID, 64'd1, "t5_stall_valid");
            probe(P_BANK,  64'd4, "t5_stall_bank");
            probe(P_REQ,   64'(mk_req(4, WRITE)), "t5_stall_req");
            tick();
        end
        bus_if.out_ready = 1'b1;
        probe(P_READY, 64'h0200, "t5_refill_ready");
        tick();
        bus_if.valid_i = '0;
        probe(P_BANK, 64'd9, "t5_refill_bank");
        probe(P_REQ,  64'(mk_req(9, WRITE)), "t5_refill_req");
        tick();

        // Reset between edges drops a held slot; restart from bank 0, READ
        bus_if.req_i[3]  = mk_req(3, WRITE);
        bus_if.valid_i   = 16'h0008;
        bus_if.out_ready = 1'b0;
        probe(P_READY, 64'h0008, "t6_ready");
        tick();
        bus_if.valid_i = '0;
        tick();
        probe(P_VALID, 64'd1, "t6_held_valid");
        probe(P_BANK,  64'd3, "t6_held_bank");
        tick();
        #2 rst_n = 1'b0;
        #1;
        probe(P_VALID, 64'd0, "t6_async_valid");
        probe(P_BANK,  64'd0, "t6_async_bank");
        probe(P_REQ,   64'd0, "t6_async_req");
        probe(P_MODE,  64'd0, "t6_async_mode");
        probe(P_READY, 64'd0, "t6_async_ready");
        tick();
        #2 rst_n = 1'b1;
        tick();
        bus_if.req_i[2]  = mk_req(2, READ);
        bus_if.req_i[12] = mk_req(12, READ);
        bus_if.valid_i   = 16'h1004;
        bus_if.out_ready = 1'b1;
        probe(P_READY, 64'h0004, "t6_restart_ready");
        probe(P_MODE,  64'd0,    "t6_restart_mode");
        expect_slot(2, mk_req(2, READ));
        expect_slot(12, mk_req(12, READ));
        tick();
        probe(P_READY, 64'h1000, "t6_second_ready");
        tick();
        bus_if.valid_i = '0;

        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        tick();
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bank_cmd_arbiter
